// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Optional access timeout is enabled by defining LSU_TIMEOUT_EN.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } lsuStateT;

    localparam logic [2:0] Func3B  = 3'b000;
    localparam logic [2:0] Func3H  = 3'b001;
    localparam logic [2:0] Func3W  = 3'b010;
    localparam logic [2:0] Func3Bu = 3'b100;
    localparam logic [2:0] Func3Hu = 3'b101;

    localparam int unsigned TimeoutCyclesDefault = 16;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables / replication, load extraction and extension,
// and detection of misaligned or illegal requests.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic        write,
    input  logic [1:0]  addrLo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic [2:0]  rdFunc3,
    input  logic [1:0]  rdAddrLo,
    output logic [3:0]  be,
    output logic [31:0] wdataRep,
    output logic [31:0] loadExt,
    output logic        misalign
);

    logic [7:0]  rdByte;
    logic [15:0] rdHalf;

    always_comb begin
        be       = 4'b1111;
        misalign = 1'b0;
        wdataRep = wdata;
        case (func3)
            Func3B: begin
                if (write) be = 4'b0001 << addrLo;
                wdataRep = {4{wdata[7:0]}};
            end
            Func3H: begin
                misalign = addrLo[0];
                if (write) be = addrLo[1] ? 4'b1100 : 4'b0011;
                wdataRep = {2{wdata[15:0]}};
            end
            Func3W:  misalign = (addrLo != 2'b00);
            // Unsigned variants exist only for loads
            Func3Bu: misalign = write;
            Func3Hu: misalign = write | addrLo[0];
            default: misalign = 1'b1;
        endcase
    end

    always_comb begin
        case (rdAddrLo)
            2'd0:    rdByte = rdata[7:0];
            2'd1:    rdByte = rdata[15:8];
            2'd2:    rdByte = rdata[23:16];
            default: rdByte = rdata[31:24];
        endcase
        rdHalf = rdAddrLo[1] ? rdata[31:16] : rdata[15:0];
        case (rdFunc3)
            Func3B:  loadExt = {{24{rdByte[7]}}, rdByte};
            Func3H:  loadExt = {{16{rdHalf[15]}}, rdHalf};
            Func3Bu: loadExt = {24'h0, rdByte};
            Func3Hu: loadExt = {16'h0, rdHalf};
            default: loadExt = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> BUSY (await mem_ack) -> DONE.
// Define LSU_TIMEOUT_EN to abort a BUSY access after TIMEOUT_CYCLES cycles without ack.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    lsuStateT    stateQ, stateD;
    logic        weQ;
    logic [2:0]  func3Q;
    logic [31:0] addrQ, wdataQ, loadDataQ;
    logic [3:0]  beQ;
    logic        loadValidQ, faultQ;

    logic [3:0]  reqBe;
    logic [31:0] reqWdata, loadExt;
    logic        reqBad, accept, timeoutHit;

    lsu_align uAlign (
        .func3    (req_func3),
        .write    (req_write),
        .addrLo   (req_addr[1:0]),
        .wdata    (req_wdata),
        .rdata    (mem_rdata),
        .rdFunc3  (func3Q),
        .rdAddrLo (addrQ[1:0]),
        .be       (reqBe),
        .wdataRep (reqWdata),
        .loadExt  (loadExt),
        .misalign (reqBad)
    );

    assign accept = (stateQ == StIdle) && req_valid && !reqBad;

    // A zero-cycle timeout is not a meaningful configuration
    if (TIMEOUT_CYCLES == 0) begin : gZeroTimeoutUnsupported
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] busyCntQ;

    always_ff @(posedge clk) begin
        if (!reset || accept) begin
            busyCntQ <= '0;
        end else if (stateQ == StBusy) begin
            busyCntQ <= busyCntQ + 1'b1;
        end
    end

    // Counter holds (n-1) on the n-th BUSY cycle
    assign timeoutHit = (stateQ == StBusy) && !mem_ack &&
                        (busyCntQ == CntW'(TIMEOUT_CYCLES - 1));
`else
    assign timeoutHit = 1'b0;
`endif

    always_comb begin
        stateD = stateQ;
        stall  = 1'b0;
        case (stateQ)
            StIdle: begin
                if (accept) begin
                    stall  = 1'b1;
                    stateD = StBusy;
                end
            end
            StBusy: begin
                stall = 1'b1;
                if (mem_ack || timeoutHit) stateD = StDone;
            end
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateQ     <= StIdle;
            weQ        <= 1'b0;
            func3Q     <= 3'b000;
            addrQ      <= '0;
            wdataQ     <= '0;
            beQ        <= '0;
            loadDataQ  <= '0;
            loadValidQ <= 1'b0;
            faultQ     <= 1'b0;
        end else begin
            stateQ     <= stateD;
            loadValidQ <= 1'b0;
            faultQ     <= 1'b0;
            if (accept) begin
                weQ    <= req_write;
                func3Q <= req_func3;
                addrQ  <= req_addr;
                wdataQ <= reqWdata;
                beQ    <= req_write ? reqBe : 4'b1111;
            end
            if ((stateQ == StIdle) && req_valid && reqBad) faultQ <= 1'b1;
            if (stateQ == StBusy) begin
                if (mem_ack) begin
                    if (!weQ) loadDataQ <= loadExt;
                    loadValidQ <= !weQ;
                end else if (timeoutHit) begin
                    loadDataQ <= '0;
                    faultQ    <= 1'b1;
                end
            end
        end
    end

    assign mem_req    = (stateQ == StBusy);
    assign mem_we     = weQ;
    assign mem_addr   = {addrQ[31:2], 2'b00};
    assign mem_be     = beQ;
    assign mem_wdata  = wdataQ;
    assign load_data  = loadDataQ;
    assign load_valid = loadValidQ;
    assign fault      = faultQ;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; timeout scenario depends on LSU_TIMEOUT_EN.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, load_valid, fault, mem_req, mem_we, mem_ack;
    logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          stalls;
        int          lvPulses;
        int          faults;
        int          busyN;
        logic        doneFault;
        logic        done;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ldata;
    } accT;

    load_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .fault      (fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Issues one request and follows it until DONE; ackCycle=0 means never acknowledge.
    task automatic run_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int ackCycle, output accT r);
        r = '{default: 0};
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_func3 = f3; req_addr = addr; req_wdata = wdata;
        mem_ack = 1'b0;
        #1;
        if (stall) r.stalls++;
        if (fault) r.faults++;
        for (int i = 0; i < 40 && !r.done; i++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            if (load_valid) r.lvPulses++;
            if (stall) r.stalls++;
            if (fault) r.faults++;
            if (mem_req) begin
                r.busyN++;
                r.be = mem_be; r.addr = mem_addr; r.wdata = mem_wdata; r.we = mem_we;
                if (r.busyN == ackCycle) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata;
                end
            end else begin
                r.done = 1'b1;
                r.doneFault = fault;
                r.ldata = load_data;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        if (load_valid) r.lvPulses++;
        if (fault) r.faults++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL reset_load_valid: got %b want 0", load_valid); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b want 0", fault); end
        checks++; if (load_data !== 32'h0) begin failures++; $display("FAIL reset_load_data: got %h want 0", load_data); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_be !== 4'h0) begin failures++; $display("FAIL reset_mem_be: got %b want 0", mem_be); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lw();
        accT r;
        run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, r);
        checks++; if (r.done !== 1'b1) begin failures++; $display("FAIL lw_done: got %b want 1", r.done); end
        checks++; if (r.stalls != 3) begin failures++; $display("FAIL lw_stalls: got %0d want 3", r.stalls); end
        checks++; if (r.busyN != 2) begin failures++; $display("FAIL lw_busy: got %0d want 2", r.busyN); end
        checks++; if (r.lvPulses != 1) begin failures++; $display("FAIL lw_load_valid: got %0d want 1", r.lvPulses); end
        checks++; if (r.ldata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data: got %h want deadbeef", r.ldata); end
        checks++; if (r.addr !== 32'h100) begin failures++; $display("FAIL lw_addr: got %h want 100", r.addr); end
        checks++; if (r.be !== 4'b1111 || r.we !== 1'b0) begin failures++; $display("FAIL lw_be_we: got %b/%b want 1111/0", r.be, r.we); end
        checks++; if (r.faults != 0) begin failures++; $display("FAIL lw_fault: got %0d want 0", r.faults); end
    endtask

    task automatic test_sub_word_loads();
        logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ad  [4] = '{32'h103, 32'h103, 32'h000, 32'h102};
        logic [31:0] rd  [4] = '{32'h80000000, 32'h80000000, 32'h0000F00D, 32'h80011234};
        logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFF00D, 32'h00008001};
        accT r;
        for (int i = 0; i < 4; i++) begin
            // Ack on the very first BUSY cycle
            run_access(1'b0, f3[i], ad[i], 32'h0, rd[i], 1, r);
            checks++; if (r.ldata !== exp[i]) begin failures++; $display("FAIL subload_%0d_data: got %h want %h", i, r.ldata, exp[i]); end
            checks++; if (r.stalls != 2 || r.lvPulses != 1) begin failures++; $display("FAIL subload_%0d_timing: got stalls=%0d lv=%0d want 2/1", i, r.stalls, r.lvPulses); end
        end
    endtask

    task automatic test_stores();
        logic [2:0]  f3  [3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] ad  [3] = '{32'h202, 32'h301, 32'h404};
        logic [31:0] wd  [3] = '{32'h1234ABCD, 32'h000000A5, 32'hCAFEF00D};
        logic [31:0] eA  [3] = '{32'h200, 32'h300, 32'h404};
        logic [3:0]  eBe [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] eWd [3] = '{32'hABCDABCD, 32'hA5A5A5A5, 32'hCAFEF00D};
        accT r;
        for (int i = 0; i < 3; i++) begin
            run_access(1'b1, f3[i], ad[i], wd[i], 32'hFFFFFFFF, 2, r);
            checks++; if (r.addr !== eA[i]) begin failures++; $display("FAIL store_%0d_addr: got %h want %h", i, r.addr, eA[i]); end
            checks++; if (r.be !== eBe[i]) begin failures++; $display("FAIL store_%0d_be: got %b want %b", i, r.be, eBe[i]); end
            checks++; if (r.wdata !== eWd[i]) begin failures++; $display("FAIL store_%0d_wdata: got %h want %h", i, r.wdata, eWd[i]); end
            checks++; if (r.we !== 1'b1 || r.lvPulses != 0) begin failures++; $display("FAIL store_%0d_we_lv: got %b/%0d want 1/0", i, r.we, r.lvPulses); end
            // Last load in test_sub_word_loads was LHU -> 0x00008001
            checks++; if (r.ldata !== 32'h00008001) begin failures++; $display("FAIL store_%0d_load_data: got %h want 00008001", i, r.ldata); end
        end
    endtask

    task automatic test_misaligned();
        logic        wr [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3 [6] = '{3'b010, 3'b001, 3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] ad [6] = '{32'h101, 32'h001, 32'h003, 32'h102, 32'h100, 32'h100};
        accT r;
        int faults, reqs, stalls;
        run_access(1'b0, 3'b010, 32'h40, 32'h0, 32'h13572468, 1, r);
        for (int i = 0; i < 6; i++) begin
            faults = 0; reqs = 0; stalls = 0;
            @(negedge clk);
            req_valid = 1'b1; req_write = wr[i]; req_func3 = f3[i]; req_addr = ad[i];
            req_wdata = 32'h55;
            #1;
            if (fault) faults++;
            if (mem_req) reqs++;
            if (stall) stalls++;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                req_valid = 1'b0;
                #1;
                if (fault) faults++;
                if (mem_req) reqs++;
                if (stall) stalls++;
            end
            checks++; if (faults != 1) begin failures++; $display("FAIL misalign_%0d_fault_cycles: got %0d want 1", i, faults); end
            checks++; if (reqs != 0 || stalls != 0) begin failures++; $display("FAIL misalign_%0d_req_stall: got %0d/%0d want 0/0", i, reqs, stalls); end
            checks++; if (load_data !== 32'h13572468) begin failures++; $display("FAIL misalign_%0d_load_data: got %h want 13572468", i, load_data); end
        end
    endtask

    task automatic test_reset_in_busy();
        int lv = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_func3 = 3'b010; req_addr = 32'h500;
        mem_ack = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rstbusy_enter: got %b want 1", mem_req); end
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rstbusy_idle: got req=%b stall=%b want 0/0", mem_req, stall); end
        checks++; if (mem_addr !== 32'h0 || load_data !== 32'h0) begin failures++; $display("FAIL rstbusy_regs: got %h/%h want 0/0", mem_addr, load_data); end
        // mem_ack stays high while idle and must be ignored
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (load_valid || mem_req) lv++;
        end
        mem_ack = 1'b0;
        checks++; if (lv != 0) begin failures++; $display("FAIL rstbusy_no_valid: got %0d want 0", lv); end
    endtask

    task automatic test_timeout();
        accT r;
`ifdef LSU_TIMEOUT_EN
        run_access(1'b0, 3'b010, 32'h600, 32'h0, 32'h0, 0, r);
        checks++; if (r.done !== 1'b1 || r.busyN != 16) begin failures++; $display("FAIL timeout_busy: got done=%b busy=%0d want 1/16", r.done, r.busyN); end
        checks++; if (r.doneFault !== 1'b1 || r.faults != 1) begin failures++; $display("FAIL timeout_fault: got %b/%0d want 1/1", r.doneFault, r.faults); end
        checks++; if (r.ldata !== 32'h0 || r.lvPulses != 0) begin failures++; $display("FAIL timeout_data: got %h/%0d want 0/0", r.ldata, r.lvPulses); end
`else
        run_access(1'b0, 3'b010, 32'h600, 32'h0, 32'h0BADF00D, 30, r);
        checks++; if (r.done !== 1'b1 || r.busyN != 30) begin failures++; $display("FAIL nowait_busy: got done=%b busy=%0d want 1/30", r.done, r.busyN); end
        checks++; if (r.faults != 0 || r.lvPulses != 1) begin failures++; $display("FAIL nowait_flags: got %0d/%0d want 0/1", r.faults, r.lvPulses); end
        checks++; if (r.ldata !== 32'h0BADF00D) begin failures++; $display("FAIL nowait_data: got %h want 0badf00d", r.ldata); end
`endif
    endtask

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_func3 = 3'b000; req_addr = 32'h0;
        req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0; reset = 1'b0;
        test_reset();
        test_lw();
        test_sub_word_loads();
        test_stores();
        test_misaligned();
        test_reset_in_busy();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum BUSY cycles to wait for mem_ack; used only when LSU_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  core requests a load or store this cycle.
REQ-005 req_write  input  1  1 = store, 0 = load.
REQ-006 req_func3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 req_addr  input  32  byte address from the ALU result.
REQ-008 req_wdata  input  32  store data (rs2).
REQ-009 stall  output  1  core must hold PC and request inputs stable.
REQ-010 load_data  output  32  extended load result, registered.
REQ-011 load_valid  output  1  one-cycle pulse: load_data is valid.
REQ-012 fault  output  1  one-cycle pulse: misaligned address, illegal func3, or timeout.
REQ-013 mem_req  output  1  memory request, held until acknowledged.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_addr  output  32  word address, req_addr with bits [1:0] forced to 00.
REQ-016 mem_be  output  4  byte-lane enables.
REQ-017 mem_wdata  output  32  lane-replicated store data.
REQ-018 mem_ack  input  1  memory completed the access.
REQ-019 mem_rdata  input  32  read word, valid when mem_ack=1.

Function
REQ-020 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-021 IDLE with req_valid=1 and a legal, aligned request SHALL latch all request fields and go to BUSY on the next edge.
REQ-022 stall SHALL be combinational: 1 in IDLE when an accepted request is present, 1 in BUSY, and 0 in DONE.
REQ-023 mem_req SHALL be 1 only in BUSY; mem_we, mem_addr, mem_be and mem_wdata SHALL be driven from latched fields and held constant while in BUSY.
REQ-024 BUSY with mem_ack=1 SHALL capture the extended mem_rdata into load_data and go to DONE; an ack on the first BUSY cycle is accepted.
REQ-025 DONE SHALL pulse load_valid=1 for loads, keep load_valid=0 for stores, ignore req_valid, and return to IDLE on the next edge.
REQ-026 Minimum latency SHALL be 3 cycles from acceptance to DONE (IDLE, BUSY, DONE).
REQ-027 Misaligned requests SHALL raise fault for one cycle in IDLE, with no mem_req, no stall and load_data unchanged; this covers:
- H/HU/SH with addr[0]=1;
- W with addr[1:0] not equal to 00;
- func3 of 011, 110 or 111 (illegal), and func3 100/101 on stores (illegal).
REQ-028 Store byte enables SHALL be set as follows:
- SB: mem_be = 0001 shifted left by addr[1:0], wdata[7:0] replicated on all 4 lanes;
- SH: mem_be = 0011 (addr[1]=0) or 1100 (addr[1]=1), wdata[15:0] replicated on both halves;
- SW: mem_be = 1111.
REQ-029 Loads SHALL drive mem_be=1111; the byte or half selected by addr[1:0] SHALL be sign-extended for B/H and zero-extended for BU/HU.
REQ-030 mem_ack outside BUSY SHALL be ignored.

Reset
REQ-031 With reset=0 at an edge, state SHALL become IDLE and load_data, load_valid, fault, mem_req, mem_we, mem_addr, mem_be and mem_wdata SHALL all be 0.
REQ-032 Reset asserted in BUSY SHALL abandon the access: no load_valid, and mem_req=0 from the next cycle.

Configuration
REQ-033 When LSU_TIMEOUT_EN is defined, a counter SHALL clear on entry to BUSY and count BUSY cycles.
REQ-034 When that count reaches TIMEOUT_CYCLES with no ack, the FSM SHALL go to DONE with fault=1, load_valid=0 and load_data=0.
REQ-035 When LSU_TIMEOUT_EN is undefined, BUSY SHALL wait indefinitely and no counter logic SHALL exist.

Structure
REQ-036 Package lsu_pkg SHALL hold the state enum, the func3 constants and the TIMEOUT_CYCLES default.
REQ-037 Sub-module lsu_align SHALL be purely combinational and generate mem_be, mem_wdata, the load extension and the misalign/illegal detection.

Verification
REQ-038 LW at 0x100, mem_ack on the 2nd BUSY cycle, mem_rdata=0xDEADBEEF -> stall for 3 cycles, then load_valid=1 with load_data=0xDEADBEEF.
REQ-039 LB at 0x103 with mem_rdata=0x80000000 -> load_data=0xFFFFFF80; LBU at the same address -> load_data=0x00000080.
REQ-040 SH at 0x202 with wdata=0x1234ABCD -> mem_addr=0x200, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, and load_valid stays 0.
REQ-041 LW at 0x101 -> fault pulses for 1 cycle, mem_req=0 and stall=0 throughout.
REQ-042 Reset driven low on the 2nd BUSY cycle -> mem_req=0 on the next cycle, state IDLE, and no load_valid.
REQ-043 LSU_TIMEOUT_EN defined, no mem_ack -> after 16 BUSY cycles, fault=1 and load_data=0, then return to IDLE.
